// File: rtl/clk_phase_divider.sv
// Programmable clock divider: a shared period counter drives N_CH channels,
// each producing a phase-offset square wave and a period-start strobe.

module clk_phase_lane #(
   parameter int CNT_W = 8
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] cnt,
   input  logic [CNT_W-1:0] div,
   input  logic [CNT_W-1:0] phase,
   output logic             outclk,
   output logic             outce
);
   logic [CNT_W:0] cnt_x, ph_x, div_x, p, half;

   // Position within this channel's period; one extra bit keeps cnt + div clean at max P.
   always_comb begin
      cnt_x = {1'b0, cnt};
      ph_x  = {1'b0, phase};
      div_x = {1'b0, div};
      half  = div_x >> 1;
      p     = (cnt_x >= ph_x) ? (cnt_x - ph_x) : (cnt_x + div_x - ph_x);
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         outclk <= 1'b0;
         outce  <= 1'b0;
      end else if (en) begin
         outclk <= (p < half);
         outce  <= (p == '0);
      end else begin
         outclk <= 1'b0;
         outce  <= 1'b0;
      end
   end
endmodule

module clk_phase_divider #(
   parameter int N_CH    = 6,
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 4
) (
   input  logic                  refclk,
   input  logic                  rst,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [CNT_W-1:0]      cfg_div,
   input  logic [N_CH*CNT_W-1:0] cfg_phase,
   output logic                  cfg_err,
   output logic [N_CH-1:0]       outclk,
   output logic [N_CH-1:0]       outce,
   output logic                  locked
);
   typedef enum logic {ALIGN, LOCKED} state_t;

   state_t                       state_q, state_d;
   logic [CNT_W-1:0]             cnt, cnt_d, div_r;
   logic [N_CH-1:0][CNT_W-1:0]   phase_r;
   logic                         cfg_ok, accept, reject, wrap;

   assign cfg_ready = (state_q == LOCKED);
   assign locked    = (state_q == LOCKED);

   always_comb begin
      cfg_ok = (cfg_div >= CNT_W'(2));
      for (int i = 0; i < N_CH; i++)
         if (cfg_phase[i*CNT_W +: CNT_W] >= cfg_div) cfg_ok = 1'b0;
      accept  = cfg_valid && cfg_ready && cfg_ok;
      reject  = cfg_valid && cfg_ready && !cfg_ok;
      wrap    = (cnt == div_r - CNT_W'(1));
      cnt_d   = wrap ? '0 : cnt + CNT_W'(1);
      state_d = state_q;
      if (accept) begin
         cnt_d   = '0;
         state_d = ALIGN;
      end else if (state_q == ALIGN && wrap) begin
         state_d = LOCKED;
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q <= ALIGN;
         cnt     <= '0;
         div_r   <= CNT_W'(DEF_DIV);
         phase_r <= '0;
         cfg_err <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt     <= cnt_d;
         cfg_err <= reject;
         if (accept) begin
            div_r   <= cfg_div;
            phase_r <= cfg_phase;
         end
      end
   end

   // Lanes see the pre-edge state, so the accepting edge still emits LOCKED outputs.
   for (genvar i = 0; i < N_CH; i++) begin : g_lane
      clk_phase_lane #(.CNT_W(CNT_W)) u_lane (
         .refclk (refclk),
         .rst    (rst),
         .en     (state_q == LOCKED),
         .cnt    (cnt),
         .div    (div_r),
         .phase  (phase_r[i]),
         .outclk (outclk[i]),
         .outce  (outce[i])
      );
   end
endmodule

// File: tb/tb_clk_phase_divider.sv
// Bench for clk_phase_divider: constant vector table after reset, directed
// reconfiguration/reset sequences and random traffic against an elapsed-time model.

module tb_clk_phase_divider;
   localparam int N_CH = 4, CNT_W = 8, DEF_DIV = 4;

   logic        refclk = 1'b0, rst = 1'b1, cfg_valid = 1'b0;
   logic [7:0]  cfg_div = '0;
   logic [31:0] cfg_phase = '0;
   logic        cfg_ready, cfg_err, locked;
   logic [3:0]  outclk, outce;

   clk_phase_divider #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
      .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
      .outclk(outclk), .outce(outce), .locked(locked));

   always #5 refclk = ~refclk;

   int n_vec = 0, n_bad = 0;

   // Model: config start edge (cnt==0 after it), ratio and phases; everything else from elapsed edges.
   int m_e = 0, m_base = 0, m_div = DEF_DIV;
   int m_ph[4] = '{0, 0, 0, 0};
   logic [3:0] e_clk, e_ce;
   logic       e_lk, e_err;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, m_e);
      end
   endtask

   task automatic model_edge();
      int c, p;
      bit lk_before, ok;
      m_e++;
      e_clk = '0; e_ce = '0; e_err = 1'b0;
      if (rst) begin
         m_base = m_e; m_div = DEF_DIV;
         for (int i = 0; i < 4; i++) m_ph[i] = 0;
      end else begin
         lk_before = (m_e - 1) >= (m_base + m_div);
         if (lk_before) begin
            c = (m_e - 1 - m_base) % m_div;
            for (int i = 0; i < 4; i++) begin
               p = (c - m_ph[i] + m_div) % m_div;
               e_clk[i] = (p < m_div / 2);
               e_ce[i]  = (p == 0);
            end
         end
         ok = (cfg_div >= 2);
         for (int i = 0; i < 4; i++) if (int'(cfg_phase[i*8 +: 8]) >= int'(cfg_div)) ok = 1'b0;
         e_err = cfg_valid && lk_before && !ok;
         if (cfg_valid && lk_before && ok) begin
            m_base = m_e; m_div = cfg_div;
            for (int i = 0; i < 4; i++) m_ph[i] = cfg_phase[i*8 +: 8];
         end
      end
      e_lk = (m_e >= m_base + m_div);
   endtask

   task automatic step();
      @(posedge refclk); #1;
      model_edge();
      chk("outclk", outclk, e_clk);
      chk("outce", outce, e_ce);
      chk("locked", locked, e_lk);
      chk("cfg_ready", cfg_ready, e_lk);
      chk("cfg_err", cfg_err, e_err);
   endtask

   task automatic offer(input logic [7:0] d, input logic [31:0] ph);
      cfg_valid = 1'b1; cfg_div = d; cfg_phase = ph;
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic check_async_zero(input string tag);
      chk({tag, "_outclk"}, outclk, 4'h0);
      chk({tag, "_outce"}, outce, 4'h0);
      chk({tag, "_locked"}, locked, 1'b0);
      chk({tag, "_ready"}, cfg_ready, 1'b0);
      chk({tag, "_err"}, cfg_err, 1'b0);
   endtask

   typedef struct {
      logic v; logic [7:0] div; logic [31:0] ph;
      logic [3:0] clk; logic [3:0] ce; logic lk; logic err;
   } vec_t;

   function automatic vec_t mk(logic v, logic [7:0] d, logic [31:0] ph,
                               logic [3:0] c, logic [3:0] e, logic lk, logic err);
      vec_t r;
      r.v = v; r.div = d; r.ph = ph; r.clk = c; r.ce = e; r.lk = lk; r.err = err;
      return r;
   endfunction

   initial begin
      vec_t tbl[13];
      int f[4], hi[4], cnt0;
      bit prev1;

      // Edges after reset release: lock at 4th, 1100 pattern, then two rejected offers.
      tbl[0]  = mk(0, 0, 0, 4'h0, 4'h0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 4'h0, 4'h0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 4'h0, 4'h0, 0, 0);
      tbl[3]  = mk(0, 0, 0, 4'h0, 4'h0, 1, 0);
      tbl[4]  = mk(0, 0, 0, 4'hF, 4'hF, 1, 0);
      tbl[5]  = mk(0, 0, 0, 4'hF, 4'h0, 1, 0);
      tbl[6]  = mk(0, 0, 0, 4'h0, 4'h0, 1, 0);
      tbl[7]  = mk(0, 0, 0, 4'h0, 4'h0, 1, 0);
      tbl[8]  = mk(0, 0, 0, 4'hF, 4'hF, 1, 0);
      tbl[9]  = mk(1, 1, 32'h0, 4'hF, 4'h0, 1, 1);
      tbl[10] = mk(1, 6, 32'h0000_0600, 4'h0, 4'h0, 1, 1);
      tbl[11] = mk(0, 0, 0, 4'h0, 4'h0, 1, 0);
      tbl[12] = mk(0, 0, 0, 4'hF, 4'hF, 1, 0);

      #2;
      check_async_zero("por");
      for (int k = 0; k < 2; k++) step();
      rst = 1'b0;
      for (int k = 0; k < 13; k++) begin
         cfg_valid = tbl[k].v; cfg_div = tbl[k].div; cfg_phase = tbl[k].ph;
         @(posedge refclk); #1;
         model_edge();
         chk($sformatf("tbl%0d_outclk", k), outclk, tbl[k].clk);
         chk($sformatf("tbl%0d_outce", k), outce, tbl[k].ce);
         chk($sformatf("tbl%0d_locked", k), locked, tbl[k].lk);
         chk($sformatf("tbl%0d_ready", k), cfg_ready, tbl[k].lk);
         chk($sformatf("tbl%0d_err", k), cfg_err, tbl[k].err);
      end
      cfg_valid = 1'b0;

      // div=6 phases {0,2,3,5}: six zero cycles, then staggered strobes, 3-of-6 high.
      offer(8'd6, {8'd5, 8'd3, 8'd2, 8'd0});
      chk("cfg6_unlock", locked, 1'b0);
      for (int k = 0; k < 6; k++) step();
      for (int i = 0; i < 4; i++) begin f[i] = -1; hi[i] = 0; end
      for (int k = 0; k < 12; k++) begin
         step();
         for (int i = 0; i < 4; i++) begin
            if (outce[i] && f[i] < 0) f[i] = k;
            hi[i] += int'(outclk[i]);
         end
      end
      chk("ce0_first", f[0], 0);
      chk("ce1_lag", f[1] - f[0], 2);
      chk("ce3_lag", f[3] - f[0], 5);
      for (int i = 0; i < 4; i++) chk($sformatf("hi6_ch%0d", i), hi[i], 6);

      // Offer held through ALIGN is ignored, then taken on the first LOCKED edge.
      offer(8'd3, 32'h0);
      cfg_valid = 1'b1; cfg_div = 8'd5; cfg_phase = 32'h0;
      for (int k = 0; k < 3; k++) step();
      chk("hold_ready", cfg_ready, 1'b1);
      step();
      cfg_valid = 1'b0;
      chk("hold_taken", locked, 1'b0);
      for (int k = 0; k < 8; k++) step();

      // Async reset mid-ALIGN, then mid-LOCKED while an output is high.
      offer(8'd6, 32'h0);
      for (int k = 0; k < 3; k++) step();
      rst = 1'b1; #1;
      check_async_zero("rst_align");
      step(); step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) step();
      chk("relock_4", locked, 1'b1);
      cnt0 = 0;
      for (int k = 0; k < 12; k++) begin step(); cnt0 += int'(outce[0]); end
      chk("period4_ce", cnt0, 3);
      for (int k = 0; k < 8 && !outclk[0]; k++) step();
      chk("pre_rst_high", outclk[0], 1'b1);
      rst = 1'b1; #1;
      check_async_zero("rst_locked");
      step();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) step();

      // Maximum period, channel 1 one cycle ahead of channel 0.
      offer(8'd255, {8'd1, 8'd127, 8'd254, 8'd0});
      for (int k = 0; k < 255; k++) step();
      for (int i = 0; i < 4; i++) hi[i] = 0;
      prev1 = 1'b0;
      for (int k = 0; k < 510; k++) begin
         step();
         if (prev1) chk("ce1_then_ce0", outce[0], 1'b1);
         prev1 = outce[1];
         if (k < 255) for (int i = 0; i < 4; i++) hi[i] += int'(outclk[i]);
      end
      for (int i = 0; i < 4; i++) chk($sformatf("hi255_ch%0d", i), hi[i], 127);

      // Random offers (some invalid) and occasional async resets.
      for (int k = 0; k < 2000; k++) begin
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 149) == 0) begin
            rst = 1'b1; #1;
            check_async_zero("rnd_rst");
         end
         cfg_valid = ($urandom_range(0, 7) == 0);
         cfg_div = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(1, 12));
         for (int i = 0; i < 4; i++)
            cfg_phase[i*8 +: 8] = 8'($urandom_range(0, int'(cfg_div)));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/clk_phase_divider.md
CLK_PHASE_DIVIDER -- requirements
Module: clk_phase_divider

Interface
REQ-001 SHALL provide parameter N_CH, default 6, number of output channels (1..16).
REQ-002 SHALL provide parameter CNT_W, default 8, width of divide ratio and phase fields.
REQ-003 SHALL provide parameter DEF_DIV, default 4, divide ratio loaded at reset (2 <= DEF_DIV <= 2^CNT_W-1).
REQ-004 SHALL have one clock and an asynchronous, active-high reset, named as below.
REQ-005 refclk  input  1  sole clock; all state rising-edge triggered.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 cfg_valid  input  1  new configuration offered.
REQ-008 cfg_ready  output  1  configuration can be accepted this cycle.
REQ-009 cfg_div  input  CNT_W  period P in refclk cycles.
REQ-010 cfg_phase  input  N_CH*CNT_W  per-channel phase offset; channel i in bits [i*CNT_W +: CNT_W].
REQ-011 cfg_err  output  1  one-cycle pulse: offered configuration rejected.
REQ-012 outclk  output  N_CH  divided, phase-shifted square waves.
REQ-013 outce  output  N_CH  one-cycle strobe at each channel's period start.
REQ-014 locked  output  1  outputs valid and phase-aligned.

Function
REQ-015 SHALL hold registers div_r, phase_r[N_CH], free-running counter cnt (0..div_r-1, wraps to 0 after div_r-1), and state in {ALIGN, LOCKED}.
REQ-016 Per channel, p_i = cnt - phase_r[i] if cnt >= phase_r[i], else cnt + div_r - phase_r[i], computed at CNT_W+1 bits with no overflow.
REQ-017 Each edge in LOCKED: outclk[i] <= (p_i < div_r>>1); outce[i] <= (p_i == 0). Outputs are registered, one cycle behind cnt.
REQ-018 Each edge in ALIGN: outclk and outce <= 0.
REQ-019 ALIGN->LOCKED on the edge where cnt wraps from div_r-1 to 0; locked <= 1 on that same edge.
REQ-020 cfg_ready SHALL equal (state == LOCKED); cfg_valid while cfg_ready=0 SHALL be ignored, with no side effects.
REQ-021 Valid configuration: cfg_div >= 2 and every phase field < cfg_div.
REQ-022 On cfg_valid && cfg_ready with valid config: div_r, phase_r <= inputs; cnt <= 0; state <= ALIGN; locked <= 0. Outputs on that edge are still computed from old LOCKED state.
REQ-023 On cfg_valid && cfg_ready with invalid config: cfg_err <= 1 for exactly one cycle; div_r, phase_r, cnt, state and outputs are unaffected.
REQ-024 cfg_err SHALL be 0 in all other cycles; back-to-back invalid offers SHALL pulse it each cycle.
REQ-025 Odd P: high time is floor(P/2) cycles and low time is ceil(P/2) cycles.
REQ-026 At maximum P = 2^CNT_W-1, the counter wrap and p_i wrap SHALL be correct.

Reset
REQ-027 rst=1 SHALL immediately force: outclk=0, outce=0, locked=0, cfg_err=0, cfg_ready=0, cnt=0, state=ALIGN, div_r=DEF_DIV, phase_r all 0.
REQ-028 Reset mid-ALIGN or mid-LOCKED SHALL discard the pending configuration; after release the block SHALL behave as from power-up.
REQ-029 After release, locked SHALL rise DEF_DIV edges later.

Verification (N_CH=4, CNT_W=8, DEF_DIV=4)
REQ-030 Release rst -> locked=1 at the 4th edge; next cycle outce=4'b1111; each outclk repeats 1,1,0,0; outce has period 4.
REQ-031 In LOCKED, offer div=6, phases {0,2,3,5} -> locked=0 next cycle, outputs 0 for 6 cycles, locked=1 again; outce[1] 2 cycles after outce[0], outce[3] 5 cycles after; each outclk high 3 of 6.
REQ-032 Offer div=1, then div=6 with phase 6 -> cfg_err pulses once per offer; locked stays 1; outclk pattern is unbroken.
REQ-033 Hold cfg_valid through ALIGN -> cfg_ready=0 and the offer is ignored; it is accepted on the first LOCKED cycle, restarting ALIGN.
REQ-034 Assert rst asynchronously mid-ALIGN after div=6 -> all outputs 0 without a clock edge; after release, period is 4 again.
REQ-035 Offer div=255, phase {0,254,127,1} -> ch1 outce precedes ch0 by one cycle; high time 127, low time 128.
